// File: rtl/dc_buffer_read_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : dc_buffer_read_ctrl_if
//  Description : Bus bundle between the dual-clock buffer read controller and
//                its surroundings (buffer read port, write token, downstream
//                valid/ready stage, read token back to the writer).
//  Revision    : 1.0 - initial release
// ============================================================================
interface dc_buffer_read_ctrl_if #(
  parameter int DATA_WIDTH   = 32,
  parameter int BUFFER_DEPTH = 8
);
  logic [BUFFER_DEPTH-1:0] write_token;
  logic [BUFFER_DEPTH-1:0] read_pointer;
  logic [DATA_WIDTH-1:0]   buffer_data;
  logic [DATA_WIDTH-1:0]   data_out;
  logic                    valid;
  logic                    ready;
  logic [BUFFER_DEPTH-1:0] read_token;
  logic                    empty;

  // Controller side
  modport slave (
    input  write_token, buffer_data, ready,
    output read_pointer, data_out, valid, read_token, empty
  );

  // Environment side (buffer, writer, downstream consumer)
  modport master (
    output write_token, buffer_data, ready,
    input  read_pointer, data_out, valid, read_token, empty
  );
endinterface
`default_nettype wire

// File: rtl/dc_buffer_read_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : dc_buffer_read_ctrl
//  Description : Consumer-domain read controller for a dual-clock buffer.
//                Owns the one-hot read pointer, synchronizes the writer's
//                one-hot token, detects empty, and presents entries through a
//                registered valid/ready output stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module dc_buffer_read_ctrl #(
  parameter int DATA_WIDTH   = 32,
  parameter int BUFFER_DEPTH = 8,
  parameter int SYNC_STAGES  = 2
) (
  input  wire logic            clk,
  input  wire logic            rst,
  dc_buffer_read_ctrl_if.slave bus
);

  localparam logic [BUFFER_DEPTH-1:0] c_ptr_one = {{(BUFFER_DEPTH-1){1'b0}}, 1'b1};

  logic [BUFFER_DEPTH-1:0] sync_q [SYNC_STAGES];
  logic [BUFFER_DEPTH-1:0] rptr_q, rptr_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    valid_q, valid_d;

  logic [BUFFER_DEPTH-1:0] wsync;
  logic                    wsync_ok;
  logic                    is_empty;
  logic                    pop;

  // Write-token synchronizer chain; every stage resets to slot 0 so empty holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= c_ptr_one;
    end else begin
      sync_q[0] <= bus.write_token;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign wsync    = sync_q[SYNC_STAGES-1];
  // A token caught mid-transition (zero or multiple bits) is treated as empty.
  assign wsync_ok = $onehot(wsync);
  assign is_empty = (wsync == rptr_q) || !wsync_ok;
  // Load a new entry when one exists and the output stage is free or draining.
  assign pop      = !is_empty && (!valid_q || bus.ready);

  // Next-state for the output stage and the pointer (pointer only moves on pop).
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    rptr_d  = rptr_q;
    if (pop) begin
      data_d  = bus.buffer_data;
      valid_d = 1'b1;
      rptr_d  = {rptr_q[BUFFER_DEPTH-2:0], rptr_q[BUFFER_DEPTH-1]};
    end else if (valid_q && bus.ready) begin
      valid_d = 1'b0;
    end
  end

  // Output stage and read pointer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      rptr_q  <= c_ptr_one;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      rptr_q  <= rptr_d;
    end
  end

  assign bus.read_pointer = rptr_q;
  assign bus.read_token   = rptr_q;
  assign bus.data_out     = data_q;
  assign bus.valid        = valid_q;
  assign bus.empty        = is_empty;

endmodule
`default_nettype wire

// File: tb/tb_dc_buffer_read_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dc_buffer_read_ctrl
//  Description : Directed self-checking bench for dc_buffer_read_ctrl with a
//                buffer/writer model and an in-order data scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dc_buffer_read_ctrl;
  localparam int DW    = 32;
  localparam int DEPTH = 8;
  localparam int SYNC  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dc_buffer_read_ctrl_if #(.DATA_WIDTH(DW), .BUFFER_DEPTH(DEPTH)) bus ();

  dc_buffer_read_ctrl #(
    .DATA_WIDTH  (DW),
    .BUFFER_DEPTH(DEPTH),
    .SYNC_STAGES (SYNC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [DW-1:0]    mem [DEPTH];
  logic [DW-1:0]    exp_q [$];
  logic [DEPTH-1:0] exp_rp;
  int               tests = 0;
  int               fails = 0;
  int               widx  = 0;

  // Buffer model: combinational read port addressed by the one-hot pointer.
  always_comb begin
    bus.buffer_data = '0;
    for (int i = 0; i < DEPTH; i++)
      if (bus.read_pointer[i]) bus.buffer_data = bus.buffer_data | mem[i];
  end

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DEPTH-1:0] rotl(input logic [DEPTH-1:0] v);
    return {v[DEPTH-2:0], v[DEPTH-1]};
  endfunction

  // Writer model: fill the slot, record the expectation, advance the token.
  task automatic write_entry(input logic [DW-1:0] d);
    mem[widx] = d;
    exp_q.push_back(d);
    widx = (widx + 1) % DEPTH;
    bus.write_token = '0;
    bus.write_token[widx] = 1'b1;
  endtask

  // Scoreboard: a handshake visible here completes on the next posedge.
  always @(negedge clk) begin
    if (!rst && bus.valid && bus.ready) begin
      check("sb_has_expected", (exp_q.size() != 0), 1);
      if (exp_q.size() != 0) check("sb_data", bus.data_out, exp_q.pop_front());
    end
  end

  initial begin
    bus.write_token = 8'h01;
    bus.ready       = 1'b0;
    exp_rp          = 8'h01;
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;

    // ---------------- reset and idle ----------------
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    check("rst_read_pointer", bus.read_pointer, 8'h01);
    check("rst_read_token",   bus.read_token,   8'h01);
    check("rst_valid",        bus.valid,        0);
    check("rst_empty",        bus.empty,        1);
    check("rst_data_out",     bus.data_out,     0);
    for (int i = 0; i < 20; i++) begin
      tick();
      check("idle_valid", bus.valid, 0);
    end
    check("idle_read_pointer", bus.read_pointer, 8'h01);
    check("idle_empty",        bus.empty,        1);

    // ---------------- single entry ----------------
    bus.ready = 1'b1;
    write_entry(32'hA5A5_0001);
    tick();
    check("single_lat1_valid", bus.valid, 0);
    tick();
    check("single_lat2_valid", bus.valid, 0);
    check("single_lat2_empty", bus.empty, 0);
    tick();
    exp_rp = rotl(exp_rp);
    check("single_valid",        bus.valid,        1);
    check("single_data_out",     bus.data_out,     32'hA5A5_0001);
    check("single_read_pointer", bus.read_pointer, exp_rp);
    tick();
    check("single_valid_drop", bus.valid, 0);
    check("single_empty",      bus.empty, 1);

    // ---------------- streaming with wrap-around ----------------
    fork
      begin : wr_stream
        for (int i = 0; i < 10; i++) begin
          write_entry(32'h1000_0000 + i);
          tick();
        end
      end
      begin : chk_stream
        int t;
        t = 0;
        while (!bus.valid && t < 20) begin
          tick();
          t++;
        end
        for (int k = 0; k < 10; k++) begin
          exp_rp = rotl(exp_rp);
          check("stream_valid", bus.valid, 1);
          check((exp_rp == 8'h01) ? "stream_wrap_rp" : "stream_rp", bus.read_pointer, exp_rp);
          if (k < 9) tick();
        end
        tick();
        check("stream_end_valid", bus.valid, 0);
        check("stream_end_empty", bus.empty, 1);
      end
    join
    check("stream_drained", exp_q.size(), 0);

    // ---------------- backpressure ----------------
    bus.ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      write_entry(32'hB000_0000 + i);
      tick();
    end
    exp_rp = rotl(exp_rp);
    check("bp_valid", bus.valid,        1);
    check("bp_rp",    bus.read_pointer, exp_rp);
    check("bp_data",  bus.data_out,     32'hB000_0000);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_hold_valid", bus.valid,        1);
      check("bp_hold_rp",    bus.read_pointer, exp_rp);
      check("bp_hold_data",  bus.data_out,     32'hB000_0000);
    end
    bus.ready = 1'b1;
    begin : drain_bp
      int t;
      t = 0;
      while ((exp_q.size() != 0 || bus.valid) && t < 20) begin
        tick();
        t++;
      end
    end
    exp_rp = rotl(rotl(exp_rp));
    check("bp_drained",   exp_q.size(),     0);
    check("bp_end_valid", bus.valid,        0);
    check("bp_end_rp",    bus.read_pointer, exp_rp);

    // ---------------- non-one-hot token ----------------
    rst = 1'b1;
    bus.write_token = 8'h01;
    bus.ready = 1'b0;
    tick();
    rst = 1'b0;
    exp_q.delete();
    widx   = 0;
    exp_rp = 8'h01;
    check("rst2_rp", bus.read_pointer, 8'h01);
    bus.ready = 1'b1;
    mem[0] = 32'hC000_0000;
    mem[1] = 32'hC000_0001;
    bus.write_token = 8'h06;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("nonhot_valid", bus.valid,        0);
      check("nonhot_rp",    bus.read_pointer, 8'h01);
      check("nonhot_empty", bus.empty,        1);
    end
    bus.write_token = 8'h04;
    exp_q.push_back(32'hC000_0000);
    exp_q.push_back(32'hC000_0001);
    widx = 2;
    tick();
    check("nonhot_sync1_valid", bus.valid, 0);
    tick();
    check("nonhot_sync2_valid", bus.valid, 0);
    tick();
    check("nonhot_pop_valid", bus.valid,    1);
    check("nonhot_pop_data",  bus.data_out, 32'hC000_0000);
    begin : drain_nh
      int t;
      t = 0;
      while ((exp_q.size() != 0 || bus.valid) && t < 20) begin
        tick();
        t++;
      end
    end
    exp_rp = 8'h04;
    check("nonhot_drained", exp_q.size(),     0);
    check("nonhot_end_rp",  bus.read_pointer, exp_rp);

    // ---------------- reset mid-stream ----------------
    bus.ready = 1'b0;
    write_entry(32'hD000_0002);
    repeat (SYNC + 1) tick();
    check("mid_pre_valid", bus.valid,        1);
    check("mid_pre_rp",    bus.read_pointer, 8'h08);
    check("mid_pre_data",  bus.data_out,     32'hD000_0002);
    rst = 1'b1;
    bus.write_token = 8'h01;
    tick();
    check("mid_rst_valid", bus.valid,        0);
    check("mid_rst_rp",    bus.read_pointer, 8'h01);
    check("mid_rst_token", bus.read_token,   8'h01);
    check("mid_rst_data",  bus.data_out,     0);
    rst = 1'b0;
    exp_q.delete();
    widx = 0;
    bus.ready = 1'b1;
    repeat (4) tick();
    check("post_rst_valid", bus.valid, 0);
    check("post_rst_empty", bus.empty, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
`default_nettype wire
